ss_window_decoder: RTL and testbench
====================================

# ss_window_decoder

Stochastic-to-binary decoder at the output end of the stochastic MAC datapath. It consumes a 1-bit stochastic stream with a per-cycle valid and counts ones over a fixed window of 2^WIN_LOG2 accepted samples. At the end of each window it presents the binary result on a valid/ready output port. It is the inverse of the comparator-based stochastic stream generators and replaces free-running accumulators with windowed, handshaked conversion.

## Interface
- WIN_LOG2, default 8: window length N = 2^WIN_LOG2 accepted samples.
- OUT_W, default WIN_LOG2+1: result width. Must not be overridden; it holds 0..N.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  in IDLE, begins a window with the counters cleared; ignored outside IDLE.
- stop  in  1  aborts the current window, discards the partial count, returns to IDLE.
- cont  in  1  continuous mode, sampled at the window end: 1 starts the next window immediately, 0 goes to IDLE.
- ss_in  in  1  stochastic bit.
- ss_valid  in  1  ss_in is a sample this cycle.
- out_data  out  OUT_W  decoded window result.
- out_valid  out  1  out_data is valid; held until accepted.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- busy  out  1  state is ACCUM.
- ovf  out  1  sticky: a window result was dropped because the output register was occupied.
- ovf_clr  in  1  clears ovf synchronously.

## Operation
- States: IDLE, ACCUM. Reset state is IDLE.
- IDLE -> ACCUM when start=1. On that edge, sample_cnt and ones_cnt clear to 0.
- In ACCUM, each edge with ss_valid=1 is one accepted sample: sample_cnt += 1 and ones_cnt += ss_in. Cycles with ss_valid=0 change neither counter.
- Window end is the accepted sample with sample_cnt == N-1. The result is ones_cnt + ss_in, which fits in OUT_W bits (max N).
- At window end: sample_cnt and ones_cnt clear. The state goes to ACCUM if cont=1, otherwise to IDLE.
- Result load: if out_valid=0, or out_valid=1 with out_ready=1 on the same edge, the result loads into out_data and out_valid=1.
- Otherwise the result is dropped, out_data keeps the older value, and ovf is set.
- out_valid clears on an edge with out_ready=1 and no new result loading.
- stop=1 has priority over sample acceptance. stop at the same edge as the window-end sample discards that window: no result is loaded and ovf is unchanged.
- start while in ACCUM is ignored.
- If ovf_clr and an overflow event occur on the same edge, set wins.
- The output register is independent of the state. A pending result survives stop and start.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, ovf=0. State IDLE, both counters 0.
- start edge -> busy=1 in the next cycle. The first sample can be accepted on the edge after start.
- Latency: out_valid rises in the cycle after the edge accepting the N-th sample.
- In continuous mode with ss_valid held at 1, results arrive every N cycles with no gap samples.
- Reset asserted mid-window clears everything immediately, asynchronously. There is no partial result.

## Configuration
- SS_DEC_BIPOLAR_EN undefined: out_data = ones count, unsigned, range 0..N.
- SS_DEC_BIPOLAR_EN defined: out_data = ones count - N/2 in two's complement, same OUT_W width, range -N/2..+N/2. This is the bipolar value (2p-1) scaled by N/2.
- The conversion is applied at result load, so there is no added latency. Counters and handshake are identical in both builds.

## Structure
- Package ss_dec_pkg holds:
  - state enum (IDLE, ACCUM);
  - localparam default WIN_LOG2;
  - the bipolar offset function.
- Sub-module ss_window_counter holds sample_cnt, ones_cnt and the window-end detect. The top level holds the FSM, output register, handshake and ovf.

## Test plan
- WIN_LOG2=8, cont=0, out_ready=1, 256 consecutive ss_in=1 samples -> out_data=9'h100, out_valid high for 1 cycle after the 256th sample, busy=0 afterwards.
- Alternating 1/0 with ss_valid=0 on every third cycle, 256 accepted samples -> out_data=128; gap cycles are not counted.
- cont=1, out_ready=0, all-ones then all-zeros windows -> out_data stays 256, ovf=1 after the second window end. Then ovf_clr -> ovf=0.
- 100 samples, stop, then start and 256 zeros -> out_data=0; no result is produced for the aborted window.
- rst low during sample 50 -> all outputs 0 on the next cycle. After release, start and 256 ones -> out_data=256.
- SS_DEC_BIPOLAR_EN defined: all-ones window -> 9'h080 (+128); all-zeros window -> 9'h180 (-128); half ones -> 0.

Source files
------------

// File: rtl/ss_window_decoder_pkg.sv
// ss_dec_pkg: shared types and helpers for the stochastic window decoder.
//   state_t        : decoder FSM state (IDLE, ACCUM)
//   WIN_LOG2_DEF   : default log2 of the window length
//   bipolar_offset : maps a ones count to the bipolar value (2p-1)*N/2
package ss_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int WIN_LOG2_DEF = 8;

  // ones - N/2, where N = 2^win_log2. The caller truncates the result to its
  // own width and reads it as two's complement.
  function automatic int bipolar_offset(input int ones, input int win_log2);
    return ones - (1 << (win_log2 - 1));
  endfunction

endpackage

// File: rtl/ss_window_counter.sv
// ss_window_counter: sample and ones counters for one decode window.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero both counters (window start or abort)
//   accept    : this edge takes ss_in as a sample
//   ss_in     : stochastic bit
//   win_end   : the current accepted sample completes the window
//   result    : ones in the window including the current sample (0..N)
module ss_window_counter
  import ss_dec_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int OUT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic             ss_in,
  output logic             win_end,
  output logic [OUT_W-1:0] result
);

  localparam logic [WIN_LOG2-1:0] LAST = '1;

  logic [WIN_LOG2-1:0] sample_cnt;
  // Before the final sample at most N-1 ones are seen, so WIN_LOG2 bits hold it.
  logic [WIN_LOG2-1:0] ones_cnt;

  assign win_end = accept && (sample_cnt == LAST);
  assign result  = OUT_W'(ones_cnt) + OUT_W'(ss_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (clear || win_end) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
      ones_cnt   <= ones_cnt + WIN_LOG2'(ss_in);
    end
  end

endmodule

// File: rtl/ss_window_decoder.sv
// ss_window_decoder: windowed stochastic-to-binary decoder.
// Counts ones over 2^WIN_LOG2 accepted samples and presents the count on a
// valid/ready output register. A result arriving while the register is still
// occupied (and not being accepted) is dropped and the sticky ovf flag is set.
// Optional feature macro: SS_DEC_BIPOLAR_EN -- when defined, out_data is the
// ones count minus N/2 in two's complement (range -N/2..+N/2).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, stop, cont   : begin window (IDLE only), abort window, auto-restart
//   ss_in, ss_valid     : stochastic bit and its sample qualifier
//   out_data, out_valid : decoded result, held until out_ready
//   out_ready           : consumer accept
//   busy                : accumulating a window
//   ovf, ovf_clr        : sticky dropped-result flag and its clear
module ss_window_decoder
  import ss_dec_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int OUT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             ss_in,
  input  logic             ss_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
);

  state_t           state;
  logic             accept;
  logic             clear;
  logic             win_end;
  logic [OUT_W-1:0] result;
  logic [OUT_W-1:0] result_conv;
  logic             can_load;

  // stop outranks sample acceptance, so an aborted window never reaches win_end.
  assign accept = (state == ACCUM) && ss_valid && !stop;
  assign clear  = ((state == IDLE) && start) || ((state == ACCUM) && stop);

  ss_window_counter #(
    .WIN_LOG2 (WIN_LOG2),
    .OUT_W    (OUT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .accept  (accept),
    .ss_in   (ss_in),
    .win_end (win_end),
    .result  (result)
  );

`ifdef SS_DEC_BIPOLAR_EN
  assign result_conv = OUT_W'(bipolar_offset(int'(result), WIN_LOG2));
`else
  assign result_conv = result;
`endif

  // The output register is free if empty or being drained on this same edge.
  assign can_load = !out_valid || out_ready;
  assign busy     = (state == ACCUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= ACCUM;
        end
        ACCUM: begin
          if (stop)         state <= IDLE;
          else if (win_end) state <= cont ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (win_end && can_load) begin
        out_data  <= result_conv;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Set has priority over clear.
      if (win_end && !can_load) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ss_window_decoder.sv
// Scoreboard bench for ss_window_decoder. A window-level reference model
// collects accepted bits in a queue and sums them when N have arrived; loaded
// results are queued and a monitor pops them on every output transfer.
module tb_ss_window_decoder;

  localparam int WIN_LOG2 = 8;
  localparam int N        = 1 << WIN_LOG2;
  localparam int OUT_W    = WIN_LOG2 + 1;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic ss_in = 1'b0, ss_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic out_valid, busy, ovf;

  always #5 clk = ~clk;

  ss_window_decoder #(.WIN_LOG2(WIN_LOG2), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .ss_in     (ss_in),
    .ss_valid  (ss_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Reference model state
  bit               m_active = 1'b0;
  bit               win_bits[$];
  bit               m_valid = 1'b0;
  logic [OUT_W-1:0] m_data = '0;
  bit               m_ovf = 1'b0;
  logic [OUT_W-1:0] sb_q[$];

  int checks = 0;
  int passes = 0;

  function automatic logic [OUT_W-1:0] conv(input int ones);
`ifdef SS_DEC_BIPOLAR_EN
    return OUT_W'(ones - N / 2);
`else
    return OUT_W'(ones);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    win_bits.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    sb_q.delete();
  endtask

  // One clock edge of the window-level behaviour, using the driven inputs.
  task automatic model_step();
    bit old_valid;
    bit produce;
    bit ovf_set;
    int res;
    old_valid = m_valid;
    produce   = 1'b0;
    ovf_set   = 1'b0;
    res       = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        win_bits.delete();
      end
    end else if (stop) begin
      m_active = 1'b0;
      win_bits.delete();
    end else if (ss_valid) begin
      win_bits.push_back(ss_in);
      if (win_bits.size() == N) begin
        foreach (win_bits[k]) res += int'(win_bits[k]);
        produce = 1'b1;
        win_bits.delete();
        m_active = cont;
      end
    end
    if (produce) begin
      if (!old_valid || out_ready) begin
        m_valid = 1'b1;
        m_data  = conv(res);
        sb_q.push_back(m_data);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (old_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (ovf_set)      m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs just after the falling edge, then advance the model.
  task automatic cyc(input bit st, input bit sp, input bit ct, input bit si,
                     input bit sv, input bit rdy, input bit oc, input bit r);
    @(negedge clk);
    #1;
    start = st; stop = sp; cont = ct; ss_in = si;
    ss_valid = sv; out_ready = rdy; ovf_clr = oc; rst = r;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_step();
  endtask

  // Monitor: samples mid-cycle, after inputs settle and before the next edge.
  initial begin
    logic [OUT_W-1:0] exp_d;
    forever begin
      @(negedge clk);
      #3;
      check("busy", int'(busy), int'(m_active));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("ovf", int'(ovf), int'(m_ovf));
      if (m_valid) check("out_data_hold", int'(out_data), int'(m_data));
      if (rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_has_entry", sb_q.size(), 1);
        end else begin
          exp_d = sb_q.pop_front();
          check("out_data_xfer", int'(out_data), int'(exp_d));
        end
      end
    end
  end

  initial begin
    int acc;
    int i;
    int ready_bias;

    // Reset state
    repeat (3) cyc(L, L, L, L, L, H, L, L);
    #2;
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);

    // All-ones window, single shot
    cyc(H, L, L, L, L, H, L, H);
    #2 check("t1_busy_after_start", int'(busy), 1);
    repeat (N - 1) cyc(L, L, L, H, H, H, L, H);
    #2 check("t1_no_early_valid", int'(out_valid), 0);
    cyc(L, L, L, H, H, H, L, H);
    #2;
    check("t1_valid", int'(out_valid), 1);
`ifdef SS_DEC_BIPOLAR_EN
    check("t1_data", int'(out_data), int'(9'h080));
`else
    check("t1_data", int'(out_data), int'(9'h100));
`endif
    check("t1_busy_done", int'(busy), 0);
    cyc(L, L, L, L, L, H, L, H);
    #2 check("t1_valid_one_cycle", int'(out_valid), 0);

    // Alternating bits with a gap every third cycle
    cyc(H, L, L, L, L, H, L, H);
    acc = 0;
    i = 0;
    while (acc < N) begin
      bit sv;
      bit si;
      sv = (i % 3 != 2);
      si = (acc % 2 == 0);
      cyc(L, L, L, si, sv, H, L, H);
      if (sv) acc++;
      i++;
    end
    #2;
    check("t2_valid", int'(out_valid), 1);
    check("t2_data", int'(out_data), int'(conv(N / 2)));
    cyc(L, L, L, L, L, H, L, H);

    // Continuous mode with a stalled consumer
    cyc(H, L, H, L, L, L, L, H);
    repeat (N) cyc(L, L, H, H, H, L, L, H);
    #2;
    check("t3_first_data", int'(out_data), int'(conv(N)));
    check("t3_ovf_clear", int'(ovf), 0);
    repeat (N) cyc(L, L, H, L, H, L, L, H);
    #2;
    check("t3_data_kept", int'(out_data), int'(conv(N)));
    check("t3_ovf_set", int'(ovf), 1);
    check("t3_still_busy", int'(busy), 1);
    cyc(L, H, L, L, L, L, H, H);
    #2;
    check("t3_ovf_cleared", int'(ovf), 0);
    check("t3_pending_survives", int'(out_valid), 1);
    cyc(L, L, L, L, L, H, L, H);
    #2 check("t3_drained", int'(out_valid), 0);

    // Abort after 100 samples, then a full zeros window
    cyc(H, L, L, L, L, H, L, H);
    repeat (100) cyc(L, L, L, H, H, H, L, H);
    cyc(L, H, L, H, H, H, L, H);
    #2 check("t4_no_abort_result", int'(out_valid), 0);
    cyc(H, L, L, L, L, H, L, H);
    repeat (N) cyc(L, L, L, L, H, H, L, H);
    #2;
    check("t4_valid", int'(out_valid), 1);
    check("t4_data", int'(out_data), int'(conv(0)));
    cyc(L, L, L, L, L, H, L, H);

    // Reset during sample 50, leaving a result pending first
    cyc(H, L, L, L, L, L, L, H);
    repeat (N) cyc(L, L, L, H, H, L, L, H);
    cyc(H, L, L, L, L, L, L, H);
    repeat (49) cyc(L, L, L, H, H, L, L, H);
    cyc(L, L, L, H, H, L, L, L);
    #2;
    check("t5_rst_data", int'(out_data), 0);
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ovf", int'(ovf), 0);
    cyc(L, L, L, L, L, H, L, L);
    cyc(H, L, L, L, L, H, L, H);
    repeat (N) cyc(L, L, L, H, H, H, L, H);
    #2 check("t5_data", int'(out_data), int'(conv(N)));
    cyc(L, L, L, L, L, H, L, H);

    // Randomized traffic
    ready_bias = 1;
    for (int c = 0; c < 8000; c++) begin
      bit st, sp, ct, si, sv, rdy, oc, r;
      if (c % 600 == 0) ready_bias = $urandom_range(0, 3);
      st  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 299) == 0);
      ct  = ($urandom_range(0, 1) == 1);
      si  = ($urandom_range(0, 1) == 1);
      sv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) < ready_bias);
      oc  = ($urandom_range(0, 31) == 0);
      r   = ($urandom_range(0, 2999) != 0);
      cyc(st, sp, ct, si, sv, rdy, oc, r);
    end

    // Drain
    repeat (4) cyc(L, H, L, L, L, H, L, H);
    #2 check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
